// File: rtl/serial_monitor.sv
// Serial boot/debug monitor: frames arrive over the UART and are decoded into
// RAM load, fill, dump, checksum or CPU-execute operations.
module serial_monitor #(
    parameter int ADDR_WIDTH     = 10,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 12000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  received,
    input  logic                  is_transmitting,
    output logic [7:0]            tx_byte,
    output logic                  transmit,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [7:0]            din,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] raddr,
    input  logic [7:0]            dout,
    input  logic                  cpu_halted,
    output logic                  cpu_reset,
    output logic [ADDR_WIDTH-1:0] startaddr,
    output logic                  monitor_control,
    output logic [4:0]            state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [4:0] {
        ST_START     = 5'd0,
        ST_ADDR_LO   = 5'd1,
        ST_CMD       = 5'd2,
        ST_LEN_HI    = 5'd3,
        ST_LEN_LO    = 5'd4,
        ST_DISPATCH  = 5'd5,
        ST_LOAD      = 5'd6,
        ST_LOAD_INC  = 5'd7,
        ST_FILL_VAL  = 5'd8,
        ST_FILL      = 5'd9,
        ST_DUMP_ADDR = 5'd10,
        ST_DUMP_WAIT = 5'd11,
        ST_DUMP_SEND = 5'd12,
        ST_SUM_ADDR  = 5'd13,
        ST_SUM_WAIT  = 5'd14,
        ST_SUM_ACC   = 5'd15,
        ST_SUM_SEND  = 5'd16,
        ST_NAK       = 5'd17,
        ST_EXEC      = 5'd18,
        ST_RUN       = 5'd19
    } state_t;

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [7:0]            addr_hi_reg, addr_hi_next;
    logic [7:0]            cmd_reg, cmd_next;
    logic [7:0]            len_hi_reg, len_hi_next;
    logic [LEN_WIDTH-1:0]  len_reg, len_next;
    logic [7:0]            sum_reg, sum_next;
    logic [7:0]            fill_reg, fill_next;
    logic [TW-1:0]         timeout_reg, timeout_next;
    logic                  exec_cnt_reg, exec_cnt_next;

    logic [7:0]            tx_byte_reg, tx_byte_next;
    logic                  transmit_reg, transmit_next;
    logic [ADDR_WIDTH-1:0] waddr_reg, waddr_next;
    logic [7:0]            din_reg, din_next;
    logic                  write_en_reg, write_en_next;
    logic [ADDR_WIDTH-1:0] raddr_reg, raddr_next;
    logic                  cpu_reset_reg, cpu_reset_next;
    logic [ADDR_WIDTH-1:0] startaddr_reg, startaddr_next;
    logic                  monitor_control_reg, monitor_control_next;

    logic [15:0] frame_addr;
    logic [15:0] frame_len;
    logic        timed_state;
    logic        len_is_zero;
    logic        len_is_one;

    assign frame_addr  = {addr_hi_reg, rx_byte};
    assign frame_len   = {len_hi_reg, rx_byte};
    assign len_is_zero = (len_reg == '0);
    assign len_is_one  = (len_reg == LEN_WIDTH'(1));
    assign timed_state = state_reg inside {ST_ADDR_LO, ST_CMD, ST_LEN_HI,
                                           ST_LEN_LO, ST_LOAD, ST_FILL_VAL};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_START;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_START:     if (received) state_next = ST_ADDR_LO;
            ST_ADDR_LO:   if (received) state_next = ST_CMD;
            ST_CMD:       if (received) state_next = ST_LEN_HI;
            ST_LEN_HI:    if (received) state_next = ST_LEN_LO;
            ST_LEN_LO:    if (received) state_next = ST_DISPATCH;
            ST_DISPATCH: begin
                case (cmd_reg)
                    8'h01:   state_next = len_is_zero ? ST_START : ST_LOAD;
                    8'h02:   state_next = len_is_zero ? ST_START : ST_DUMP_ADDR;
                    8'h03:   state_next = ST_EXEC;
                    8'h04:   state_next = ST_FILL_VAL;
                    8'h05:   state_next = len_is_zero ? ST_SUM_SEND : ST_SUM_ADDR;
                    default: state_next = ST_NAK;
                endcase
            end
            ST_LOAD:      if (received) state_next = ST_LOAD_INC;
            ST_LOAD_INC:  state_next = len_is_zero ? ST_START : ST_LOAD;
            ST_FILL_VAL:  if (received) state_next = len_is_zero ? ST_START : ST_FILL;
            ST_FILL:      if (len_is_one) state_next = ST_START;
            ST_DUMP_ADDR: state_next = ST_DUMP_WAIT;
            ST_DUMP_WAIT: state_next = ST_DUMP_SEND;
            ST_DUMP_SEND: if (!is_transmitting) state_next = len_is_one ? ST_START : ST_DUMP_ADDR;
            ST_SUM_ADDR:  state_next = ST_SUM_WAIT;
            ST_SUM_WAIT:  state_next = ST_SUM_ACC;
            ST_SUM_ACC:   state_next = len_is_one ? ST_SUM_SEND : ST_SUM_ADDR;
            ST_SUM_SEND:  if (!is_transmitting) state_next = ST_START;
            ST_NAK:       if (!is_transmitting) state_next = ST_START;
            ST_EXEC:      if (exec_cnt_reg) state_next = ST_RUN;
            ST_RUN:       if (cpu_halted) state_next = ST_START;
            default:      state_next = ST_START;
        endcase
        // A stalled header or payload abandons the frame silently.
        if (timed_state && !received && timeout_reg == TIMEOUT_LAST) state_next = ST_START;
    end

    // Output and datapath next values
    always_comb begin
        addr_next            = addr_reg;
        addr_hi_next         = addr_hi_reg;
        cmd_next             = cmd_reg;
        len_hi_next          = len_hi_reg;
        len_next             = len_reg;
        sum_next             = sum_reg;
        fill_next            = fill_reg;
        exec_cnt_next        = 1'b0;
        tx_byte_next         = tx_byte_reg;
        transmit_next        = 1'b0;
        waddr_next           = waddr_reg;
        din_next             = din_reg;
        write_en_next        = 1'b0;
        raddr_next           = raddr_reg;
        startaddr_next       = startaddr_reg;
        cpu_reset_next       = (state_next == ST_EXEC);
        monitor_control_next = !(state_next == ST_EXEC || state_next == ST_RUN);

        if (received && (state_reg inside {ST_START, ST_ADDR_LO, ST_CMD, ST_LEN_HI,
                                           ST_LEN_LO, ST_LOAD, ST_FILL_VAL})) begin
            tx_byte_next  = rx_byte;
            transmit_next = 1'b1;
        end

        case (state_reg)
            ST_START:    if (received) addr_hi_next = rx_byte;
            ST_ADDR_LO:  if (received) addr_next = frame_addr[ADDR_WIDTH-1:0];
            ST_CMD:      if (received) cmd_next = rx_byte;
            ST_LEN_HI:   if (received) len_hi_next = rx_byte;
            ST_LEN_LO:   if (received) len_next = frame_len[LEN_WIDTH-1:0];
            ST_DISPATCH: begin
                sum_next   = 8'h00;
                raddr_next = addr_reg;
                if (cmd_reg == 8'h03) startaddr_next = addr_reg;
            end
            ST_LOAD: begin
                if (received) begin
                    waddr_next    = addr_reg;
                    din_next      = rx_byte;
                    write_en_next = 1'b1;
                    len_next      = len_reg - 1'b1;
                end
            end
            ST_LOAD_INC: addr_next = addr_reg + 1'b1;
            ST_FILL_VAL: if (received) fill_next = rx_byte;
            ST_FILL: begin
                waddr_next    = addr_reg;
                din_next      = fill_reg;
                write_en_next = 1'b1;
                addr_next     = addr_reg + 1'b1;
                len_next      = len_reg - 1'b1;
            end
            ST_DUMP_SEND: begin
                if (!is_transmitting) begin
                    tx_byte_next  = dout;
                    transmit_next = 1'b1;
                    addr_next     = addr_reg + 1'b1;
                    raddr_next    = addr_reg + 1'b1;
                    len_next      = len_reg - 1'b1;
                end
            end
            ST_SUM_ACC: begin
                sum_next   = sum_reg + dout;
                addr_next  = addr_reg + 1'b1;
                raddr_next = addr_reg + 1'b1;
                len_next   = len_reg - 1'b1;
            end
            ST_SUM_SEND: begin
                if (!is_transmitting) begin
                    tx_byte_next  = sum_reg;
                    transmit_next = 1'b1;
                end
            end
            ST_NAK: begin
                if (!is_transmitting) begin
                    tx_byte_next  = 8'h3F;
                    transmit_next = 1'b1;
                end
            end
            ST_EXEC: exec_cnt_next = 1'b1;
            default: ;
        endcase

        if (received || state_next != state_reg || !timed_state) timeout_next = '0;
        else                                                     timeout_next = timeout_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_reg            <= '0;
            addr_hi_reg         <= '0;
            cmd_reg             <= '0;
            len_hi_reg          <= '0;
            len_reg             <= '0;
            sum_reg             <= '0;
            fill_reg            <= '0;
            timeout_reg         <= '0;
            exec_cnt_reg        <= 1'b0;
            tx_byte_reg         <= '0;
            transmit_reg        <= 1'b0;
            waddr_reg           <= '0;
            din_reg             <= '0;
            write_en_reg        <= 1'b0;
            raddr_reg           <= '0;
            cpu_reset_reg       <= 1'b0;
            startaddr_reg       <= '0;
            monitor_control_reg <= 1'b1;
        end else begin
            addr_reg            <= addr_next;
            addr_hi_reg         <= addr_hi_next;
            cmd_reg             <= cmd_next;
            len_hi_reg          <= len_hi_next;
            len_reg             <= len_next;
            sum_reg             <= sum_next;
            fill_reg            <= fill_next;
            timeout_reg         <= timeout_next;
            exec_cnt_reg        <= exec_cnt_next;
            tx_byte_reg         <= tx_byte_next;
            transmit_reg        <= transmit_next;
            waddr_reg           <= waddr_next;
            din_reg             <= din_next;
            write_en_reg        <= write_en_next;
            raddr_reg           <= raddr_next;
            cpu_reset_reg       <= cpu_reset_next;
            startaddr_reg       <= startaddr_next;
            monitor_control_reg <= monitor_control_next;
        end
    end

    assign tx_byte         = tx_byte_reg;
    assign transmit        = transmit_reg;
    assign waddr           = waddr_reg;
    assign din             = din_reg;
    assign write_en        = write_en_reg;
    assign raddr           = raddr_reg;
    assign cpu_reset       = cpu_reset_reg;
    assign startaddr       = startaddr_reg;
    assign monitor_control = monitor_control_reg;
    assign state           = state_reg;

endmodule

// File: doc/serial_monitor.md
SERIAL_MONITOR -- requirements
Module: serial_monitor

Interface
REQ-001 Parameters SHALL be: ADDR_WIDTH, default 10, RAM address width; LEN_WIDTH, default 16, transfer-length width; TIMEOUT_CYCLES, default 12000000, header/load inter-byte timeout in clocks.
REQ-002 Reset SHALL be synchronous and active-high; ports SHALL be named clk and rst.
REQ-003 Ports, listed as name, direction, width, meaning:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_byte  in  8  UART received byte
- received  in  1  one-cycle strobe; rx_byte valid
- is_transmitting  in  1  UART transmitter busy
- tx_byte  out  8  byte to send
- transmit  out  1  one-cycle send strobe
- waddr  out  ADDR_WIDTH  RAM write address
- din  out  8  RAM write data
- write_en  out  1  RAM write strobe
- raddr  out  ADDR_WIDTH  RAM read address
- dout  in  8  RAM read data; valid 2 cycles after raddr changes
- cpu_halted  in  1  CPU has executed halt
- cpu_reset  out  1  CPU reset pulse
- startaddr  out  ADDR_WIDTH  CPU start address
- monitor_control  out  1  1 = monitor owns RAM and UART; 0 = CPU owns them
- state  out  5  current state, for LEDs

Function
REQ-004 A command frame SHALL be 5 bytes, in this order: ADDR_HI, ADDR_LO, CMD, LEN_HI, LEN_LO. Address and length SHALL be 16 bits. Only ADDR[ADDR_WIDTH-1:0] SHALL be used, and LEN SHALL be truncated to LEN_WIDTH.
REQ-005 States SHALL be: START, ADDR_LO, CMD, LEN_HI, LEN_LO, DISPATCH, LOAD, LOAD_INC, FILL_VAL, FILL, DUMP_ADDR, DUMP_WAIT, DUMP_SEND, SUM_ADDR, SUM_WAIT, SUM_ACC, SUM_SEND, NAK, EXEC, RUN.
REQ-006 Each header byte SHALL be echoed: tx_byte set to the byte and transmit pulsed in the cycle after received.
REQ-007 DISPATCH SHALL decode CMD as follows:
- 0x01 -> LOAD
- 0x02 -> DUMP_ADDR
- 0x03 -> EXEC
- 0x04 -> FILL_VAL
- 0x05 -> SUM_ADDR
- any other value -> NAK
REQ-008 NAK SHALL wait for !is_transmitting, then send 0x3F and go to START.
REQ-009 LOAD SHALL, on each received byte, write it to the current address (write_en high exactly 1 cycle), echo it, and decrement the remaining length. LOAD_INC SHALL then increment the address. The block SHALL return to START when the remaining length reaches 0.
REQ-010 FILL_VAL SHALL receive one value byte and echo it. FILL SHALL then write that value to LEN consecutive addresses, one per cycle, with no UART traffic.
REQ-011 DUMP SHALL, per byte, present raddr (DUMP_ADDR), wait one cycle (DUMP_WAIT), then in DUMP_SEND wait for !is_transmitting, send dout, and increment the address. This SHALL repeat LEN times.
REQ-012 SUM SHALL read LEN bytes using the same address/wait timing as DUMP, accumulate an 8-bit sum modulo 256 in SUM_ACC, then send that sum once in SUM_SEND (after !is_transmitting).
REQ-013 The address SHALL wrap modulo 2^ADDR_WIDTH.
REQ-014 LEN = 0 SHALL cause the following, with no RAM access in any case:
- LOAD, FILL, DUMP -> immediately START (FILL still consumes its value byte);
- SUM -> send 0x00.
REQ-015 EXEC SHALL:
- drive startaddr from the frame address;
- assert cpu_reset for exactly 2 consecutive cycles;
- drive monitor_control low from the first reset cycle;
- enter RUN.
REQ-016 In RUN, received bytes SHALL be ignored by the monitor. When cpu_halted is high, monitor_control SHALL go to 1 and the state SHALL go to START on the next clock.
REQ-017 cpu_halted while not in RUN SHALL have no effect.
REQ-018 A timeout counter SHALL reset on every received strobe and on every state change. In ADDR_LO, CMD, LEN_HI, LEN_LO, LOAD and FILL_VAL, reaching TIMEOUT_CYCLES with no byte SHALL return the block to START with no write and no transmit.
REQ-019 transmit, write_en and cpu_reset SHALL be single-cycle pulses, except that cpu_reset SHALL be a 2-cycle pulse during EXEC. At most one transmit SHALL occur per cycle.
REQ-020 The state output SHALL reflect the current state encoding, with START = 0.

Reset
REQ-021 On rst the block SHALL:
- set state to START;
- set monitor_control = 1;
- set transmit, write_en and cpu_reset to 0;
- set tx_byte, din, waddr, raddr and startaddr to 0;
- set address, length, sum and timeout registers to 0.
REQ-022 rst SHALL abort any operation in progress, including RUN. Any partially received frame SHALL be discarded.

Verification
REQ-023 Load: frame 00 10 01 00 03 followed by AA BB CC -> all 8 bytes echoed; RAM[0x10..0x12] = AA, BB, CC; state = START.
REQ-024 Dump and checksum:
- frame 00 10 02 00 03 -> echo, then AA BB CC;
- frame 00 10 05 00 03 -> echo, then 0x31.
REQ-025 Wrap (ADDR_WIDTH=10): frame 03 FF 04 00 02 with value 5A -> RAM[0x3FF] = RAM[0x000] = 5A, and no other write.
REQ-026 Exec: frame 00 20 03 00 00 ->
- startaddr = 0x020;
- cpu_reset high for 2 cycles;
- monitor_control = 0;
- then cpu_halted pulse -> monitor_control = 1 and state = START next cycle.
REQ-027 Errors (TIMEOUT_CYCLES=100):
- frame byte CMD = 0x07 -> 0x3F sent and state = START;
- bytes 00 10 then 100 idle cycles -> state = START, after which a full valid frame is accepted.
REQ-028 rst asserted mid-LOAD after 1 of 3 bytes -> all outputs at reset values; the following frame is decoded from ADDR_HI.
